mppc_coinc_counter: RTL
=======================

// Module: mppc_coinc_counter
// PURPOSE
//  N-channel successor to the fixed 4-channel MPPC front end. It takes the digitised MPPC
//  discriminator outputs and counts rising edges per channel over a programmable gate. It also
//  counts N-fold coincidences over a runtime channel mask with a programmable window.
//  At each gate end it snapshots all counts into shadow registers for the readout mux (SPI/UART side).
// PARAMETERS
//  N_CH     8   number of input channels (2..16)
//  CNT_W    16  width of each event counter (saturating)
//  WIN_W    4   width of coincidence window length, in CLK cycles
//  GATE_W   24  width of gate length, in CLK cycles (2^24 cycles at 9.6 MHz is about 1.75 s)
//  SEL_W    $clog2(N_CH+1), localparam, readout select width
// PORTS
//  CLK          in   1        system clock, 9.6 MHz
//  RST          in   1        synchronous, active-high reset
//  ch_in        in   N_CH     async digitised channel levels
//  enable       in   1        1 = run gates back-to-back; 0 = abort and idle
//  coinc_mask   in   N_CH     channels required for coincidence; 0 = coincidence off
//  win_len      in   WIN_W    coincidence window length in cycles; 0 = same-cycle only
//  gate_len     in   GATE_W   gate length in cycles; 0 = invalid, block stays IDLE
//  rd_sel       in   SEL_W    0..N_CH-1 = channel count; N_CH = coincidence count; else 0
//  rd_data      out  CNT_W    registered shadow[rd_sel]
//  rd_ovf       out  1        registered shadow overflow flag for rd_sel
//  gate_done    out  1        1-cycle pulse when new shadow values are valid
//  coinc_pulse  out  1        1-cycle pulse per counted coincidence (GPIO/LED)
//  ch_hit       out  N_CH     per-channel window-armed level (LED drive)
// BEHAVIOUR
//  Reset: all flops 0; FSM=IDLE; rd_data, rd_ovf, gate_done, coinc_pulse and ch_hit are all 0.
//  Input path: 2-flop synchroniser, then prev flop.
//   - edge[i] = sync[i] & ~prev[i].
//   - A rise first sampled at clock T gives edge high in cycle T+1..T+2.
//   - The live count updates at T+2.
//  Window per channel: win_cnt[i] loads win_len on edge[i], else decrements while nonzero.
//   - armed[i] = edge[i] | (win_cnt[i] != 0).
//   - ch_hit = registered armed.
//  Coincidence (cycle-wise):
//   - Condition: coinc_mask != 0, AND all masked channels are armed, AND at least one masked
//     channel has edge this cycle.
//   - Effect: coincidence count +1 and coinc_pulse high the next cycle.
//   - A retrigger inside an open window counts again (intended).
//  FSM IDLE/RUN:
//   - IDLE -> RUN when enable=1 and gate_len!=0.
//   - On entry to RUN: live counters and overflow flags cleared, gate_cnt = gate_len-1.
//   - RUN: gate_cnt decrements each cycle.
//   - Last cycle (gate_cnt=0): shadow <= next-live value, so events in the last cycle are included.
//     Live is cleared the same cycle, gate_done=1 next cycle, gate_cnt reloads.
//     Stay in RUN if enable=1 and gate_len!=0, else go IDLE. No dead time between gates.
//   - enable=0 mid-gate: next cycle IDLE; live cleared; shadow unchanged; no gate_done.
//   - gate_len/win_len/coinc_mask changes take effect at next reload/edge; no glitch protection.
//  Counters:
//   - Saturate at 2^CNT_W-1 and set a sticky live ovf bit; the ovf bit is copied to shadow at snapshot.
//   - Simultaneous edges on several channels are each counted independently.
//  Readout:
//   - rd_data/rd_ovf = shadow[rd_sel] registered, 1-cycle latency.
//   - An out-of-range rd_sel reads 0.
//   - Shadow is stable between gate_done pulses.
//  RST in any state: immediate return to reset values, including shadow.
// TESTING
//  1 gate_len=100, win_len=0, ch_in[0] 5 rises -> gate_done once after 100 RUN cycles;
//    rd_sel=0 gives 5; rd_sel=1 gives 0.
//  2 mask=0b0011, win_len=3, ch0 rises at t, ch1 at t+2 -> coinc count 1, coinc_pulse once;
//    ch1 at t+5 -> count 0.
//  3 win_len=0, ch0 and ch1 rise same cycle -> coinc 1; 1 cycle apart -> 0.
//  4 CNT_W=4, 20 rises on ch2 in one gate -> rd_data=15, rd_ovf=1;
//    next gate with 0 rises -> 0, rd_ovf=0.
//  5 edge landing in last gate cycle -> counted in closing shadow; next gate's shadow excludes it.
//  6 enable dropped mid-gate, or RST mid-gate -> no gate_done; shadow holds prior (abort) or 0 (RST).

Source files
------------

// File: rtl/mppc_coinc_counter.sv
// N-channel MPPC front end: per-channel rising-edge counters over a programmable
// gate, masked N-fold coincidence counting with a per-channel window, and
// shadow snapshots at each gate end for the slow readout side.
module mppc_coinc_counter #(
  parameter int  N_CH   = 8,
  parameter int  CNT_W  = 16,
  parameter int  WIN_W  = 4,
  parameter int  GATE_W = 24,
  localparam int SEL_W  = $clog2(N_CH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_CH-1:0]   ch_in,
  input  logic              enable,
  input  logic [N_CH-1:0]   coinc_mask,
  input  logic [WIN_W-1:0]  win_len,
  input  logic [GATE_W-1:0] gate_len,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_ovf,
  output logic              gate_done,
  output logic              coinc_pulse,
  output logic [N_CH-1:0]   ch_hit
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [GATE_W-1:0] gate_cnt, gate_cnt_nxt;
  logic              last, clr, run;

  logic [N_CH-1:0]             sync1, sync2, prev, rise, armed;
  logic [N_CH-1:0][WIN_W-1:0]  win_cnt;
  logic                        coinc;

  // Lane N_CH of the counter bank is the coincidence counter.
  logic [N_CH:0]              inc;
  logic [N_CH:0][CNT_W-1:0]   live, live_nxt, sh_cnt;
  logic [N_CH:0]              ovf, ovf_nxt, sh_ovf;

  assign rise = sync2 & ~prev;
  assign run  = (state == RUN);
  assign inc  = {coinc & run, rise & {N_CH{run}}};

  // A channel is armed on its own edge cycle and while its window is open.
  always_comb begin
    armed = rise;
    for (int i = 0; i < N_CH; i++)
      if (win_cnt[i] != '0) armed[i] = 1'b1;
  end

  // Every masked channel armed, and at least one masked channel fresh this cycle,
  // so a retrigger inside an open window counts again.
  assign coinc = (coinc_mask != '0) && ((armed & coinc_mask) == coinc_mask) &&
                 ((rise & coinc_mask) != '0);

  // Synchroniser, edge history, window countdown and LED level.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1   <= '0;
      sync2   <= '0;
      prev    <= '0;
      win_cnt <= '0;
      ch_hit  <= '0;
    end else begin
      sync1  <= ch_in;
      sync2  <= sync1;
      prev   <= sync2;
      ch_hit <= armed;
      for (int i = 0; i < N_CH; i++) begin
        if (rise[i])                win_cnt[i] <= win_len;
        else if (win_cnt[i] != '0)  win_cnt[i] <= win_cnt[i] - WIN_W'(1);
      end
    end
  end

  // Gate FSM next state; live counters are held clear whenever not mid-gate.
  always_comb begin
    state_nxt    = state;
    gate_cnt_nxt = gate_cnt;
    last         = 1'b0;
    clr          = 1'b1;
    case (state)
      IDLE: begin
        if (enable && gate_len != '0) begin
          state_nxt    = RUN;
          gate_cnt_nxt = gate_len - GATE_W'(1);
        end
      end
      RUN: begin
        if (gate_cnt == '0) begin
          // Gate end wins over an enable drop in the same cycle.
          last = 1'b1;
          if (enable && gate_len != '0) gate_cnt_nxt = gate_len - GATE_W'(1);
          else                          state_nxt    = IDLE;
        end else if (!enable) begin
          state_nxt = IDLE;
        end else begin
          clr          = 1'b0;
          gate_cnt_nxt = gate_cnt - GATE_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gate FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      gate_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gate_cnt <= gate_cnt_nxt;
    end
  end

  // Saturating increment with sticky overflow for all lanes.
  always_comb begin
    live_nxt = live;
    ovf_nxt  = ovf;
    for (int i = 0; i <= N_CH; i++) begin
      if (inc[i]) begin
        if (live[i] == '1) ovf_nxt[i]  = 1'b1;
        else               live_nxt[i] = live[i] + CNT_W'(1);
      end
    end
  end

  // Live counters and shadows; the snapshot takes next-live so last-cycle events land.
  always_ff @(posedge CLK) begin
    if (RST) begin
      live   <= '0;
      ovf    <= '0;
      sh_cnt <= '0;
      sh_ovf <= '0;
    end else begin
      live <= clr ? '0 : live_nxt;
      ovf  <= clr ? '0 : ovf_nxt;
      if (last) begin
        sh_cnt <= live_nxt;
        sh_ovf <= ovf_nxt;
      end
    end
  end

  // Registered pulses and readout mux; out-of-range selects read zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      gate_done   <= 1'b0;
      coinc_pulse <= 1'b0;
      rd_data     <= '0;
      rd_ovf      <= 1'b0;
    end else begin
      gate_done   <= last;
      coinc_pulse <= coinc & run;
      if (rd_sel <= SEL_W'(N_CH)) begin
        rd_data <= sh_cnt[rd_sel];
        rd_ovf  <= sh_ovf[rd_sel];
      end else begin
        rd_data <= '0;
        rd_ovf  <= 1'b0;
      end
    end
  end

endmodule
